// File: rtl/alu_cmd_driver.sv
// Initiator for the 8-pin ALU: packs {op,b,a} into the ALU input word, waits the
// ALU latency, captures the output word and returns it on a valid/ready response port.
module alu_cmd_driver #(
  parameter int unsigned ALU_LAT   = 1,
  parameter logic [7:0]  IDLE_WORD = 8'h00
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_a,
  input  logic [2:0] cmd_b,
  output logic [7:0] alu_in,
  input  logic [7:0] alu_out,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [5:0] rsp_result,
  output logic [1:0] rsp_op,
  output logic       rsp_err,
  output logic       rsp_divz,
  output logic       busy
);

  localparam logic [3:0] LAT = 4'(ALU_LAT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [2:0] b_q, b_d;
  logic [7:0] alu_in_q, alu_in_d;
  logic [5:0] result_q, result_d;
  logic [1:0] rop_q, rop_d;
  logic       err_q, err_d;
  logic       divz_q, divz_d;

  assign cmd_ready  = (state_q == S_IDLE) & ~rst;
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign alu_in     = alu_in_q;
  assign rsp_result = result_q;
  assign rsp_op     = rop_q;
  assign rsp_err    = err_q;
  assign rsp_divz   = divz_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    b_d      = b_q;
    alu_in_d = alu_in_q;
    result_d = result_q;
    rop_d    = rop_q;
    err_d    = err_q;
    divz_d   = divz_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d     = cmd_op;
          b_d      = cmd_b;
          alu_in_d = {cmd_op, cmd_b, cmd_a};
          cnt_d    = LAT;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Error check uses the op latched at issue, never the live cmd_op.
          result_d = alu_out[5:0];
          rop_d    = alu_out[7:6];
          err_d    = (alu_out[7:6] != op_q);
          divz_d   = (op_q == 2'b11) && (b_q == 3'd0);
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      op_q     <= 2'b00;
      b_q      <= 3'd0;
      alu_in_q <= IDLE_WORD;
      result_q <= 6'd0;
      rop_q    <= 2'b00;
      err_q    <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      alu_in_q <= alu_in_d;
      result_q <= result_d;
      rop_q    <= rop_d;
      err_q    <= err_d;
      divz_q   <= divz_d;
    end
  end

endmodule
